// File: rtl/dds_sweep_ctrl.sv
//------------------------------------------------------------------------------
// dds_sweep_ctrl : stepped frequency-sweep scheduler for a DDS phase accumulator.
// Optional macro DDS_SWEEP_PINGPONG_EN: continuous sweeps bounce instead of restart.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dds_sweep_ctrl #(
  parameter int FW      = 32,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FW-1:0]      cfg_start_freq,
  input  logic [FW-1:0]      cfg_stop_freq,
  input  logic [FW-1:0]      cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_continuous,
  input  logic               start,
  input  logic               abort,
  output logic [FW-1:0]      freq_out,
  output logic               busy,
  output logic               point_tick,
  output logic [15:0]        point_idx,
  output logic               done
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [FW-1:0]      r_start_f;
  logic [FW-1:0]      r_stop_f;
  logic [FW-1:0]      r_step;
  logic [DWELL_W-1:0] r_dwell_m1;
  logic               r_cont;
  logic [DWELL_W-1:0] r_cnt;
  logic [FW-1:0]      r_freq;
  logic [15:0]        r_idx;
  logic               r_tick;
  logic               r_done;

  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [FW-1:0]      w_freq_nxt;
  logic [15:0]        w_idx_nxt;
  logic               w_tick_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic [DWELL_W-1:0] w_dwell_m1_cfg;
  logic [FW:0]        w_sum;
  logic               w_up_end;

  // A dwell of zero behaves exactly like a dwell of one.
  assign w_dwell_m1_cfg = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);

  assign w_sum    = {1'b0, r_freq} + {1'b0, r_step};
  assign w_up_end = w_sum[FW] | (w_sum[FW-1:0] > r_stop_f) |
                    (r_step == '0) | (r_start_f > r_stop_f);

`ifdef DDS_SWEEP_PINGPONG_EN
  logic        r_down;
  logic        w_down_nxt;
  logic [FW:0] w_diff;
  logic        w_dn_end;

  assign w_diff   = {1'b0, r_freq} - {1'b0, r_step};
  assign w_dn_end = w_diff[FW] | (w_diff[FW-1:0] < r_start_f) |
                    (r_step == '0) | (r_start_f > r_stop_f);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_freq_nxt  = r_freq;
    w_idx_nxt   = r_idx;
    w_tick_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
    w_down_nxt  = r_down;
`endif
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_DWELL;
          w_load      = 1'b1;
          w_freq_nxt  = cfg_start_freq;
          w_idx_nxt   = 16'd0;
          w_tick_nxt  = 1'b1;
          w_cnt_nxt   = w_dwell_m1_cfg;
`ifdef DDS_SWEEP_PINGPONG_EN
          w_down_nxt  = 1'b0;
`endif
        end
      end
      S_DWELL: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else begin
          // Every branch below starts a new point except single-sweep completion.
          w_cnt_nxt  = r_dwell_m1;
          w_tick_nxt = 1'b1;
          w_idx_nxt  = r_idx + 16'd1;
`ifdef DDS_SWEEP_PINGPONG_EN
          if (!r_down) begin
            if (!w_up_end) begin
              w_freq_nxt = w_sum[FW-1:0];
            end else if (!r_cont) begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_tick_nxt  = 1'b0;
              w_idx_nxt   = r_idx;
            end else if (!w_dn_end) begin
              w_freq_nxt = w_diff[FW-1:0];
              w_down_nxt = 1'b1;
            end else begin
              w_freq_nxt = r_start_f;
            end
          end else begin
            if (!w_dn_end) begin
              w_freq_nxt = w_diff[FW-1:0];
            end else if (!w_up_end) begin
              w_freq_nxt = w_sum[FW-1:0];
              w_down_nxt = 1'b0;
            end else begin
              w_freq_nxt = r_start_f;
              w_down_nxt = 1'b0;
            end
          end
`else
          if (!w_up_end) begin
            w_freq_nxt = w_sum[FW-1:0];
          end else if (!r_cont) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_tick_nxt  = 1'b0;
            w_idx_nxt   = r_idx;
          end else begin
            w_freq_nxt = r_start_f;
          end
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_f  <= '0;
      r_stop_f   <= '0;
      r_step     <= '0;
      r_dwell_m1 <= '0;
      r_cont     <= 1'b0;
      r_cnt      <= '0;
      r_freq     <= '0;
      r_idx      <= '0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
      r_down     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_freq  <= w_freq_nxt;
      r_idx   <= w_idx_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
`ifdef DDS_SWEEP_PINGPONG_EN
      r_down  <= w_down_nxt;
`endif
      if (w_load) begin
        r_start_f  <= cfg_start_freq;
        r_stop_f   <= cfg_stop_freq;
        r_step     <= cfg_step;
        r_dwell_m1 <= w_dwell_m1_cfg;
        r_cont     <= cfg_continuous;
      end
    end
  end

  assign freq_out   = r_freq;
  assign busy       = (r_state == S_DWELL);
  assign point_tick = r_tick;
  assign point_idx  = r_idx;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS phase accumulator. It steps a 32-bit frequency control word from a start value to a stop value in fixed increments and holds each point for a programmable dwell time. Its output drives the accumulator's frequency input directly. A per-point tick lets downstream capture logic align its sampling to each frequency step.

## Interface
- FW, 32, frequency word width; fixed to match the accumulator input.
- DWELL_W, 24, width of the dwell-count configuration.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start_freq  in  FW  first sweep point.
- cfg_stop_freq  in  FW  upper sweep limit, inclusive.
- cfg_step  in  FW  increment per point.
- cfg_dwell  in  DWELL_W  cycles each point is held; 0 is treated as 1.
- cfg_continuous  in  1  0 = single sweep; 1 = repeat until abort.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  one-cycle request to stop the sweep.
- freq_out  out  FW  frequency word to the accumulator.
- busy  out  1  high while a sweep is running.
- point_tick  out  1  one-cycle pulse in the first cycle of each new point.
- point_idx  out  16  index of the current point since start; wraps modulo 2^16.
- done  out  1  one-cycle pulse when a single sweep completes.

## Operation
- States: IDLE and DWELL.
- Reset value of every output is 0, and the state is IDLE.
- IDLE → DWELL on `start`:
  - latch all cfg_* inputs into shadow registers;
  - freq_out = start_freq; point_idx = 0; point_tick = 1;
  - load the dwell counter with max(dwell,1) − 1.
- Configuration changes during a sweep have no effect until the next `start`.
- DWELL:
  - decrement the counter each cycle;
  - at counter == 0, compute next = freq_out + step in FW+1 bits.
- End-of-sweep condition:
  - carry out of the FW+1-bit sum, or next > stop, or step == 0, or start > stop;
  - the sweep never clamps to stop and never emits a word above stop.
- At counter == 0 when not at end:
  - freq_out = next; point_idx += 1; point_tick = 1; reload the counter.
- At counter == 0 at end, single mode: go to IDLE; busy = 0; done = 1 for one cycle.
- At counter == 0 at end, continuous mode:
  - restart at start_freq; point_idx += 1; point_tick = 1;
  - done is never asserted in continuous mode.
- freq_out holds its last value in IDLE, so the DDS keeps running at the final point.
- `abort` while in DWELL:
  - go to IDLE next cycle; busy = 0; done = 0; freq_out holds.
- `start` while busy is ignored.
- `start` and `abort` asserted in the same cycle: abort wins in either state; a start from IDLE is not taken.
- Asynchronous reset mid-sweep: all outputs and state return to 0/IDLE immediately; the shadow registers clear.

## Timing
- Start latency: `start` sampled at edge k gives freq_out, busy = 1 and point_tick after edge k.
- Each point holds freq_out for exactly max(dwell,1) cycles.
- point_tick coincides with the first cycle of each new freq_out value.
- Single sweep of N points:
  - busy is high for N × max(dwell,1) cycles;
  - done pulses in the first cycle after busy falls.
- Abort latency: one edge.
- Back-to-back `start` is accepted in the cycle done is high, since the state is already IDLE.

## Configuration
- DDS_SWEEP_PINGPONG_EN defined: at the top end in continuous mode, direction reverses rather than restarting.
  - The down step is next = freq_out − step, computed with borrow.
  - Reversal back to up occurs when next < start or a borrow occurs.
  - Endpoints are not repeated: 100,110,120,130,120,110,100,110…
  - Single mode is unaffected.
- DDS_SWEEP_PINGPONG_EN undefined: continuous mode restarts at start_freq as described above; no subtractor and no direction register are built.

## Test plan
- Single sweep: start = 100, stop = 130, step = 10, dwell = 3.
  - Required: freq_out 100,110,120,130, 3 cycles each; four ticks; busy for 12 cycles; done one cycle later; freq_out holds 130.
- Non-aligned stop: start = 0, stop = 25, step = 10, dwell = 0.
  - Required: points 0,10,20, 1 cycle each; done; 30 never appears.
- Overflow: start = 0xFFFF_FFF0, stop = 0xFFFF_FFFF, step = 0x20, dwell = 2.
  - Required: single point 0xFFFF_FFF0 for 2 cycles, then done.
- Continuous mode with abort: 100→130, step 10, dwell 1, no macro.
  - Required: 100,110,120,130,100,110…; point_idx = 5 at the second 110.
  - Abort at the second 110: busy drops next edge; freq_out stays 110; no done.
- Same-cycle start + abort in IDLE, then start during busy.
  - Required: first start not taken; second start ignored, sweep unchanged.
  - Assert rst_n low mid-point: all outputs 0 immediately.
- With DDS_SWEEP_PINGPONG_EN: 100→130, step 10, continuous.
  - Required: 100,110,120,130,120,110,100,110.
